// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral with a NUM_REGS x DATA_W read/write register bank.
// Every SPI pin is resynchronised into clk; the register contents drive regs_flat.
module spi_reg_bank #(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 7,
    parameter int                NUM_REGS  = 5,
    parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}}
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sclk,
    input  logic                         copi,
    input  logic                         ncs,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         wr_pulse,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err
);
    localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 2);

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_HDR_LAST = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] CNT_HDR_DONE = CNT_W'(ADDR_W + 1);
    localparam logic [CNT_W-1:0] CNT_FRAME    = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(FRAME_LEN + 1);
    localparam logic [ADDR_W:0]  NUM_REGS_V   = (ADDR_W + 1)'(NUM_REGS);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HDR    = 2'd1;
    localparam logic [1:0] DATA   = 2'd2;
    localparam logic [1:0] COMMIT = 2'd3;

    logic sclk_meta_r, sclk_sync_r, sclk_prev_r;
    logic copi_meta_r, copi_sync_r;
    logic ncs_meta_r, ncs_sync_r, ncs_prev_r;

    logic [1:0]                   state_r;
    logic                         armed_r;
    logic [CNT_W-1:0]             bit_cnt_r;
    logic [ADDR_W:0]              hdr_sr_r;
    logic [DATA_W-1:0]            data_sr_r;
    logic [DATA_W-1:0]            tx_sr_r;
    logic [NUM_REGS*DATA_W-1:0]   regs_flat_r;
    logic                         cipo_r, cipo_oe_r, wr_pulse_r, frame_err_r;
    logic [ADDR_W-1:0]            wr_addr_r;

    logic                         sclk_rise_s, sclk_fall_s, ncs_rise_s, ncs_fall_s;
    logic [ADDR_W:0]              hdr_next_s;
    logic [DATA_W-1:0]            rd_data_s;
    logic [ADDR_W-1:0]            commit_addr_s;
    logic                         len_ok_s, in_range_s, wr_en_s;

    // Edge detection on the synchronised pins and commit decode.
    always_comb begin
        sclk_rise_s   = sclk_sync_r & ~sclk_prev_r;
        sclk_fall_s   = ~sclk_sync_r & sclk_prev_r;
        ncs_rise_s    = ncs_sync_r & ~ncs_prev_r;
        ncs_fall_s    = ~ncs_sync_r & ncs_prev_r;
        hdr_next_s    = {hdr_sr_r[ADDR_W-1:0], copi_sync_r};
        commit_addr_s = hdr_sr_r[ADDR_W-1:0];
        len_ok_s      = (bit_cnt_r == CNT_FRAME);
        in_range_s    = ({1'b0, commit_addr_s} < NUM_REGS_V);
        wr_en_s       = (state_r == COMMIT) && len_ok_s && hdr_sr_r[ADDR_W] && in_range_s;
    end

    // Read mux for the address completing on this rise; unmapped addresses read as zero.
    always_comb begin
        rd_data_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_data_s = (hdr_next_s[ADDR_W-1:0] == ADDR_W'(i)) ?
                        regs_flat_r[i*DATA_W +: DATA_W] : rd_data_s;
        end
    end

    // Register bank: only a complete, in-range write frame updates it.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_flat_r <= {NUM_REGS{RESET_VAL}};
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en_s && (commit_addr_s == ADDR_W'(i))) begin
                    regs_flat_r[i*DATA_W +: DATA_W] <= data_sr_r;
                end
            end
        end
    end

    // Synchronisers, frame FSM, shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_meta_r <= 1'b0; sclk_sync_r <= 1'b0; sclk_prev_r <= 1'b0;
            copi_meta_r <= 1'b0; copi_sync_r <= 1'b0;
            ncs_meta_r  <= 1'b0; ncs_sync_r  <= 1'b0; ncs_prev_r  <= 1'b0;
            state_r     <= IDLE;
            armed_r     <= 1'b0;
            bit_cnt_r   <= {CNT_W{1'b0}};
            hdr_sr_r    <= {(ADDR_W+1){1'b0}};
            data_sr_r   <= {DATA_W{1'b0}};
            tx_sr_r     <= {DATA_W{1'b0}};
            cipo_r      <= 1'b0;
            cipo_oe_r   <= 1'b0;
            wr_pulse_r  <= 1'b0;
            frame_err_r <= 1'b0;
            wr_addr_r   <= {ADDR_W{1'b0}};
        end else begin
            sclk_meta_r <= sclk;      sclk_sync_r <= sclk_meta_r; sclk_prev_r <= sclk_sync_r;
            copi_meta_r <= copi;      copi_sync_r <= copi_meta_r;
            ncs_meta_r  <= ncs;       ncs_sync_r  <= ncs_meta_r;  ncs_prev_r  <= ncs_sync_r;
            wr_pulse_r  <= 1'b0;
            frame_err_r <= 1'b0;
            cipo_oe_r   <= armed_r & ~ncs_sync_r;
            cipo_r      <= (state_r == DATA) & tx_sr_r[DATA_W-1];
            if (ncs_rise_s) begin
                state_r <= COMMIT;
            end else begin
                case (state_r)
                    IDLE: begin
                        bit_cnt_r <= {CNT_W{1'b0}};
                        if (ncs_fall_s) begin
                            state_r   <= HDR;
                            armed_r   <= 1'b1;
                            hdr_sr_r  <= {(ADDR_W+1){1'b0}};
                            data_sr_r <= {DATA_W{1'b0}};
                        end
                    end
                    HDR: begin
                        if (sclk_rise_s) begin
                            hdr_sr_r  <= hdr_next_s;
                            bit_cnt_r <= bit_cnt_r + CNT_ONE;
                            if (bit_cnt_r == CNT_HDR_LAST) begin
                                state_r <= DATA;
                                tx_sr_r <= rd_data_s;
                            end
                        end
                    end
                    DATA: begin
                        if (sclk_rise_s) begin
                            data_sr_r <= {data_sr_r[DATA_W-2:0], copi_sync_r};
                            if (bit_cnt_r != CNT_SAT) begin
                                bit_cnt_r <= bit_cnt_r + CNT_ONE;
                            end
                        // The fall right after the header keeps the MSB on cipo for the first data rise.
                        end else if (sclk_fall_s && (bit_cnt_r != CNT_HDR_DONE)) begin
                            tx_sr_r <= {tx_sr_r[DATA_W-2:0], 1'b0};
                        end
                    end
                    COMMIT: begin
                        state_r     <= IDLE;
                        armed_r     <= 1'b0;
                        bit_cnt_r   <= {CNT_W{1'b0}};
                        tx_sr_r     <= {DATA_W{1'b0}};
                        frame_err_r <= armed_r & ~len_ok_s;
                        if (wr_en_s) begin
                            wr_pulse_r <= 1'b1;
                            wr_addr_r  <= commit_addr_s;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign cipo      = cipo_r;
    assign cipo_oe   = cipo_oe_r;
    assign regs_flat = regs_flat_r;
    assign wr_pulse  = wr_pulse_r;
    assign wr_addr   = wr_addr_r;
    assign frame_err = frame_err_r;
endmodule
